// File: rtl/serial_addsub_if.sv
// Handshake/data bundle for serial_addsub: operand request side and result side.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per clock, carry held in a
// register between slices. One operation in flight; result held until taken.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, acc_r, acc_nxt;
    logic             carry_r;
    logic [KW-1:0]    k_r;
    logic             last;
    logic [IW-1:0]    base;
    logic [DIGIT-1:0] sa, sb, ss;
    logic [DIGIT:0]   c;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r, ovf_r;

    assign last     = (k_r == KW'(N - 1));
    assign base     = IW'(32'(k_r) * DIGIT);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

    // Current slice: ripple DIGIT full adders from the carry register and
    // merge the slice sum into the accumulated result.
    always_comb begin
        sa      = a_r[base +: DIGIT];
        sb      = b_r[base +: DIGIT];
        ss      = '0;
        c       = '0;
        c[0]    = carry_r;
        for (int i = 0; i < DIGIT; i++) begin
            ss[i]   = sa[i] ^ sb[i] ^ c[i];
            c[i+1]  = (sa[i] & sb[i]) | (c[i] & (sa[i] ^ sb[i]));
        end
        acc_nxt = acc_r;
        acc_nxt[base +: DIGIT] = ss;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs; a new operation is only taken in IDLE,
    // so acceptance never coincides with a result handoff.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, slice iteration, and result load on the final slice.
    // Subtract is a + ~b + ~cin, so cout=1 means no borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            k_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.a;
                        b_r     <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.sub ? ~bus.cin : bus.cin;
                        acc_r   <= '0;
                        k_r     <= '0;
                    end
                end
                RUN: begin
                    acc_r   <= acc_nxt;
                    carry_r <= c[DIGIT];
                    k_r     <= last ? '0 : k_r + KW'(1);
                    if (last) begin
                        sum_r  <= acc_nxt;
                        cout_r <= c[DIGIT];
                        ovf_r  <= c[DIGIT] ^ c[DIGIT-1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
